reorder_buffer: RTL
===================

// Module: reorder_buffer
// PURPOSE
//   Tomasulo reorder buffer: allocates ROB tags at issue, captures results from the CDB,
//   retires entries in program order onto the register-file commit port, and raises the
//   branch-mispredict flush (xbp) at commit. Drives regfile's in_rob_commit_* / in_rob_xbp.
// PARAMETERS
//   ROB_SIZE   16  entries incl. reserved tag 0; usable tags 1..ROB_SIZE-1 (15 entries)
//   ROB_WIDTH  4   tag width, = log2(ROB_SIZE)
// PORTS
//   clk                 in   1   clock, all state updates on posedge
//   rst                 in   1   synchronous reset, active-high
//   rdy                 in   1   global ready; state frozen when 0
//   in_issue_valid      in   1   allocate one entry this cycle
//   in_issue_dest_reg   in   5   destination arch reg (0 = none)
//   in_issue_is_branch  in   1   entry is a conditional branch
//   in_issue_pred_taken in   1   predictor decision at fetch
//   in_issue_pc         in   32  instruction PC
//   out_issue_tag       out  4   tag the next allocation receives (= tail)
//   out_full            out  1   no free entry; issue must not assert
//   in_cdb_valid        in   1   CDB broadcast valid
//   in_cdb_tag          in   4   producing ROB tag
//   in_cdb_value        in   32  result value
//   in_cdb_taken        in   1   resolved branch direction
//   in_cdb_target       in   32  resolved branch target
//   in_query_tag1/2     in   4   operand tags the decoder checks
//   out_query_ready1/2  out  1   tagged entry holds its result
//   out_query_value1/2  out  32  that result
//   out_commit_reg      out  5   retiring dest reg (0 = no commit)
//   out_commit_rob      out  4   retiring tag
//   out_commit_value    out  32  retiring value
//   out_xbp             out  1   mispredict flush pulse
//   out_xbp_pc          out  32  redirect PC
// BEHAVIOUR
//   - Reset: head=tail=1, count=0, all valid/ready bits 0; all outputs 0 except out_issue_tag=1.
//   - Pointers advance 1..15 then wrap to 1; tag 0 never allocated.
//   - out_full = (count==15) from registered count; a same-cycle commit frees a slot only next cycle.
//   - Issue (rdy & in_issue_valid & !full): write entry[tail], ready=0, tail++, count++.
//   - CDB: if in_cdb_valid and entry[tag] valid: store value/taken/target, ready=1.
//     CDB to an empty entry or tag 0 is ignored.
//   - Query is combinational: ready/value from entry, bypassing the CDB when in_cdb_tag
//     matches the query tag. Tag 0 or an empty entry -> ready=0, value=0.
//   - Commit: at most one per cycle, when entry[head] valid and ready.
//     Outputs registered, one-cycle pulses: out_commit_reg/rob/value = entry fields;
//     head++, count--. Idle/frozen cycles drive out_commit_reg=0, out_commit_rob=0, out_xbp=0.
//   - Branch commit: out_commit_reg=0. If taken != pred_taken: out_xbp=1;
//     out_xbp_pc = taken ? target : pc+4 (mod 2^32). Same edge: all entries invalidated,
//     head=tail=1, count=0, and any same-cycle issue is dropped.
//   - Issue, CDB and commit may all occur in one cycle: count += issue - commit.
//   - rdy=0: no state change; registered outputs go to idle values.
//   - rst during any activity overrides everything; in-flight entries are discarded.
// STRUCTURE
//   - Shared in riscv/src/definition.v: ROB_POS_TYPE, REG_POS_TYPE, DATA_TYPE, ZERO_ROB,
//     ZERO_REG, ZERO_WORD, TRUE/FALSE, ROB_SIZE.
//   - One sub-module, rob_ptr_inc: combinational wrapping increment 15->1.
//   - Entry storage as parallel arrays (valid, ready, dest, value, is_branch, pred, taken, target, pc).
// TESTING
//   - Reset, then issue dest=x5 pc=0x100 -> tag 1; CDB tag1=0x2A -> next cycle
//     commit_reg=5, rob=1, value=0x2A.
//   - Issue tags 1,2; CDB tag2 first then tag1 -> commits in order 1 then 2 on consecutive cycles.
//   - Issue 15 entries without CDB -> out_full=1, 16th issue ignored. Commit one -> full
//     drops the next cycle; the next issue gets tag 1 (wrap).
//   - Branch pc=0x200, pred=0, CDB taken=1, target=0x300 -> out_xbp=1, xbp_pc=0x300;
//     next cycle count=0, issue_tag=1. With pred=1/taken=0 -> xbp_pc=0x204.
//   - CDB tag 3 with query_tag1=3 in the same cycle -> ready1=1, value1=CDB value.
//   - Hold rdy=0 during a ready head -> no commit, regs frozen. rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer.
//   rob_pos_t  : ROB tag / pointer (tag 0 is reserved and never allocated)
//   reg_pos_t  : architectural register index (0 = no destination)
//   data_t     : 32-bit datapath word
//   commit_t   : registered commit/redirect bundle driven toward the register file
package reorder_buffer_pkg;

    localparam int ROB_SIZE   = 16;
    localparam int ROB_WIDTH  = 4;
    localparam int REG_WIDTH  = 5;
    localparam int DATA_WIDTH = 32;

    typedef logic [ROB_WIDTH-1:0]  rob_pos_t;
    typedef logic [REG_WIDTH-1:0]  reg_pos_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam rob_pos_t ZERO_ROB  = '0;
    localparam rob_pos_t FIRST_ROB = rob_pos_t'(1);
    localparam rob_pos_t LAST_ROB  = rob_pos_t'(ROB_SIZE - 1);
    localparam reg_pos_t ZERO_REG  = '0;
    localparam data_t    ZERO_WORD = '0;

    typedef struct packed {
        reg_pos_t creg;
        rob_pos_t rob;
        data_t    value;
        logic     xbp;
        data_t    xbp_pc;
    } commit_t;

    // Fetch restarts at the resolved target when taken, otherwise at the
    // fall-through instruction (wraps modulo 2^32).
    function automatic data_t redirect_pc(logic taken, data_t target, data_t pc);
        return taken ? target : pc + 32'd4;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Handshake bundle between the issue/CDB/decoder side and the reorder buffer.
//   in_issue_*   : allocation request (valid, dest reg, branch info, pc)
//   out_issue_*  : tag for the next allocation, full flag
//   in_cdb_*     : result broadcast (tag, value, resolved direction/target)
//   in_query_*   : operand tags looked up by the decoder
//   out_query_*  : ready flag and value for each looked-up tag
//   out_commit_* : registered retire port toward the register file
//   out_xbp*     : mispredict flush pulse and redirect pc
// Modports: slave = reorder buffer, master = the block driving issue/CDB/query.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic     in_issue_valid;
    reg_pos_t in_issue_dest_reg;
    logic     in_issue_is_branch;
    logic     in_issue_pred_taken;
    data_t    in_issue_pc;
    rob_pos_t out_issue_tag;
    logic     out_full;

    logic     in_cdb_valid;
    rob_pos_t in_cdb_tag;
    data_t    in_cdb_value;
    logic     in_cdb_taken;
    data_t    in_cdb_target;

    rob_pos_t in_query_tag1;
    rob_pos_t in_query_tag2;
    logic     out_query_ready1;
    logic     out_query_ready2;
    data_t    out_query_value1;
    data_t    out_query_value2;

    reg_pos_t out_commit_reg;
    rob_pos_t out_commit_rob;
    data_t    out_commit_value;
    logic     out_xbp;
    data_t    out_xbp_pc;

    modport slave (
        input  in_issue_valid, in_issue_dest_reg, in_issue_is_branch, in_issue_pred_taken, in_issue_pc,
        output out_issue_tag, out_full,
        input  in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
        input  in_query_tag1, in_query_tag2,
        output out_query_ready1, out_query_ready2, out_query_value1, out_query_value2,
        output out_commit_reg, out_commit_rob, out_commit_value, out_xbp, out_xbp_pc
    );

    modport master (
        output in_issue_valid, in_issue_dest_reg, in_issue_is_branch, in_issue_pred_taken, in_issue_pc,
        input  out_issue_tag, out_full,
        output in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
        output in_query_tag1, in_query_tag2,
        input  out_query_ready1, out_query_ready2, out_query_value1, out_query_value2,
        input  out_commit_reg, out_commit_rob, out_commit_value, out_xbp, out_xbp_pc
    );

endinterface

// File: rtl/reorder_buffer_ptr_inc.sv
// Wrapping ROB pointer increment: 1,2,...,15 then back to 1, skipping the
// reserved tag 0.
//   ptr      : current pointer
//   ptr_next : pointer after one advance
module rob_ptr_inc
    import reorder_buffer_pkg::*;
(
    input  rob_pos_t ptr,
    output rob_pos_t ptr_next
);

    assign ptr_next = (ptr == LAST_ROB) ? FIRST_ROB : ptr + rob_pos_t'(1);

endmodule

// File: rtl/reorder_buffer.sv
// Tomasulo reorder buffer. Allocates tags at issue, captures CDB results,
// retires in program order onto the register-file commit port and raises the
// branch-mispredict flush at commit.
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   rdy  : global ready; state frozen and commit outputs idle when low
//   bus  : reorder_buffer_if.slave (issue, CDB, operand query, commit, xbp)
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    reorder_buffer_if.slave bus
);

    logic [ROB_SIZE-1:0] ent_valid;
    logic [ROB_SIZE-1:0] ent_ready;
    logic [ROB_SIZE-1:0] ent_is_branch;
    logic [ROB_SIZE-1:0] ent_pred;
    logic [ROB_SIZE-1:0] ent_taken;
    reg_pos_t            ent_dest   [ROB_SIZE];
    data_t               ent_value  [ROB_SIZE];
    data_t               ent_target [ROB_SIZE];
    data_t               ent_pc     [ROB_SIZE];

    rob_pos_t head, tail, head_inc, tail_inc;
    logic [ROB_WIDTH-1:0] count;

    logic    full, issue_fire, commit_fire, mispredict, cdb_hit;
    commit_t commit_d, commit_q;

    logic [1:0][ROB_WIDTH-1:0]  q_tag;
    logic [1:0]                 q_ready;
    logic [1:0][DATA_WIDTH-1:0] q_value;

    rob_ptr_inc u_head_inc (.ptr(head), .ptr_next(head_inc));
    rob_ptr_inc u_tail_inc (.ptr(tail), .ptr_next(tail_inc));

    // Full comes from the registered count, so a commit frees its slot for
    // issue only on the following cycle.
    assign full = (count == LAST_ROB);

    assign cdb_hit = bus.in_cdb_valid && (bus.in_cdb_tag != ZERO_ROB) && ent_valid[bus.in_cdb_tag];

    always_comb begin
        commit_fire = rdy && ent_valid[head] && ent_ready[head];
        mispredict  = commit_fire && ent_is_branch[head] && (ent_taken[head] != ent_pred[head]);
        // A flush wipes the window, so an issue in the same cycle is dropped.
        issue_fire  = rdy && bus.in_issue_valid && !full && !mispredict;
        commit_d    = '0;
        if (commit_fire) begin
            commit_d.creg  = ent_is_branch[head] ? ZERO_REG : ent_dest[head];
            commit_d.rob   = head;
            commit_d.value = ent_value[head];
            commit_d.xbp   = mispredict;
            if (mispredict) begin
                commit_d.xbp_pc = redirect_pc(ent_taken[head], ent_target[head], ent_pc[head]);
            end
        end
    end

    // Operand lookup with CDB bypass so the decoder sees a result in the same
    // cycle it is broadcast.
    assign q_tag[0] = bus.in_query_tag1;
    assign q_tag[1] = bus.in_query_tag2;

    always_comb begin
        q_ready = '0;
        q_value = '0;
        for (int i = 0; i < 2; i++) begin
            if ((q_tag[i] != ZERO_ROB) && ent_valid[q_tag[i]]) begin
                if (bus.in_cdb_valid && (bus.in_cdb_tag == q_tag[i])) begin
                    q_ready[i] = 1'b1;
                    q_value[i] = bus.in_cdb_value;
                end else if (ent_ready[q_tag[i]]) begin
                    q_ready[i] = 1'b1;
                    q_value[i] = ent_value[q_tag[i]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= FIRST_ROB;
            tail      <= FIRST_ROB;
            count     <= '0;
            ent_valid <= '0;
            ent_ready <= '0;
            commit_q  <= '0;
        end else if (!rdy) begin
            commit_q <= '0;
        end else begin
            commit_q <= commit_d;

            if (cdb_hit) begin
                ent_ready[bus.in_cdb_tag]  <= 1'b1;
                ent_value[bus.in_cdb_tag]  <= bus.in_cdb_value;
                ent_taken[bus.in_cdb_tag]  <= bus.in_cdb_taken;
                ent_target[bus.in_cdb_tag] <= bus.in_cdb_target;
            end

            if (issue_fire) begin
                ent_valid[tail]     <= 1'b1;
                ent_ready[tail]     <= 1'b0;
                ent_dest[tail]      <= bus.in_issue_dest_reg;
                ent_is_branch[tail] <= bus.in_issue_is_branch;
                ent_pred[tail]      <= bus.in_issue_pred_taken;
                ent_pc[tail]        <= bus.in_issue_pc;
                tail                <= tail_inc;
            end

            if (commit_fire) begin
                ent_valid[head] <= 1'b0;
                ent_ready[head] <= 1'b0;
                head            <= head_inc;
            end

            case ({issue_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (mispredict) begin
                ent_valid <= '0;
                ent_ready <= '0;
                head      <= FIRST_ROB;
                tail      <= FIRST_ROB;
                count     <= '0;
            end
        end
    end

    assign bus.out_issue_tag    = tail;
    assign bus.out_full         = full;
    assign bus.out_query_ready1 = q_ready[0];
    assign bus.out_query_ready2 = q_ready[1];
    assign bus.out_query_value1 = q_value[0];
    assign bus.out_query_value2 = q_value[1];
    assign bus.out_commit_reg   = commit_q.creg;
    assign bus.out_commit_rob   = commit_q.rob;
    assign bus.out_commit_value = commit_q.value;
    assign bus.out_xbp          = commit_q.xbp;
    assign bus.out_xbp_pc       = commit_q.xbp_pc;

endmodule
